// File: rtl/acc_flags_unit.sv
// -----------------------------------------------------------------------------
// acc_flags_unit
//
// Purpose:
//   Captures ALU results. Each accepted result can be written into an
//   accumulator, which feeds back to ALU operand A. Its flags can be written
//   into a last-flags register, and they are always OR-ed into a sticky flags
//   register. Every accepted result is also queued, with its flags, in a small
//   result FIFO for a downstream consumer. The FIFO head is registered, so the
//   outputs have no combinational path from the inputs.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   alu_result    W-bit signed ALU result
//   alu_flags     4-bit ALU flags (opaque)
//   in_valid      alu_result/alu_flags valid this cycle
//   in_ready      block can accept a result (count < DEPTH)
//   acc_we        accepted result is written to the accumulator
//   flags_we      accepted flags are written to flags_q
//   acc_clr       clear the accumulator (wins over acc_we)
//   sticky_clr    clear the sticky flags (an accepted push in the same cycle
//                 still ORs in after the clear)
//   acc           accumulator register
//   flags_q       last written flags
//   flags_sticky  OR of all accepted flags since the last clear
//   out_valid     FIFO head valid (count > 0)
//   out_ready     consumer takes the head this cycle
//   out_data      FIFO head result (holds its last value when empty)
//   out_flags     FIFO head flags  (holds its last value when empty)
// -----------------------------------------------------------------------------
module acc_flags_unit #(
  parameter int W     = 16,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         acc_we,
  input  logic         flags_we,
  input  logic         acc_clr,
  input  logic         sticky_clr,
  output logic [W-1:0] acc,
  output logic [3:0]   flags_q,
  output logic [3:0]   flags_sticky,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   flags;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  entry_t        in_entry;
  entry_t        head_next;

  // Handshakes depend only on registered count. A full FIFO refuses a push
  // even when it is popped in the same cycle.
  assign in_ready = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign in_entry = '{data: alu_result, flags: alu_flags};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_next = rd_ptr;
    count_next = count;
    if (pop) rd_next = rd_ptr + PW'(1);
    if (push && !pop) count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
    // The next head is the entry being pushed now when it lands at the next
    // read slot: a push into an empty FIFO, or a push and pop at count 1.
    // Otherwise the next head is already in storage.
    head_next = mem[rd_next];
    if (push && (wr_ptr == rd_next)) head_next = in_entry;
  end

  // NOTE: the storage array is not reset. Its contents matter only between
  // the pointers, and the pointers are reset. Leaving it unreset lets it map
  // to plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_data     <= '0;
      out_flags    <= '0;
      acc          <= '0;
      flags_q      <= '0;
      flags_sticky <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      // The head registers hold their last value once the FIFO drains.
      if (count_next != '0) {out_data, out_flags} <= head_next;

      if (acc_clr) acc <= '0;
      else if (push && acc_we) acc <= alu_result;

      if (push && flags_we) flags_q <= alu_flags;

      // A clear acts first, then the push's flags are OR-ed in.
      if (sticky_clr) flags_sticky <= push ? alu_flags : 4'b0000;
      else if (push) flags_sticky <= flags_sticky | alu_flags;
    end
  end

endmodule

// File: tb/tb_acc_flags_unit.sv
// -----------------------------------------------------------------------------
// tb_acc_flags_unit
//
// Purpose:
//   Self-checking bench for acc_flags_unit (W=16, DEPTH=4). Directed steps
//   drive one cycle at a time. Expected FIFO entries go into a scoreboard queue
//   when a push is driven and come out when the model pops them. After each
//   edge, the registers and the FIFO head are compared with a small reference
//   model.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_acc_flags_unit;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   flags;
  } entry_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         in_valid;
  logic         in_ready;
  logic         acc_we;
  logic         flags_we;
  logic         acc_clr;
  logic         sticky_clr;
  logic [W-1:0] acc;
  logic [3:0]   flags_q;
  logic [3:0]   flags_sticky;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [3:0]   out_flags;

  acc_flags_unit #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .alu_flags(alu_flags),
    .in_valid(in_valid), .in_ready(in_ready), .acc_we(acc_we),
    .flags_we(flags_we), .acc_clr(acc_clr), .sticky_clr(sticky_clr),
    .acc(acc), .flags_q(flags_q), .flags_sticky(flags_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  entry_t       sb[$];
  entry_t       m_last;
  logic [W-1:0] m_acc;
  logic [3:0]   m_fq;
  logic [3:0]   m_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle at the negedge, update the model, clock it, and compare.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [3:0] f,
                     input logic awe, input logic fwe, input logic aclr,
                     input logic sclr, input logic ordy, input logic rs);
    logic   push;
    logic   pop;
    entry_t head;
    rst = rs; in_valid = v; alu_result = d; alu_flags = f; acc_we = awe;
    flags_we = fwe; acc_clr = aclr; sticky_clr = sclr; out_ready = ordy;
    if (rs) begin
      sb.delete();
      m_last = '0; m_acc = '0; m_fq = '0; m_st = '0;
    end else begin
      push = v && (sb.size() < DEPTH);
      pop  = ordy && (sb.size() > 0);
      if (pop) begin
        m_last = sb[0];
        sb.pop_front();
      end
      if (push) sb.push_back('{data: d, flags: f});
      if (aclr) m_acc = '0;
      else if (push && awe) m_acc = d;
      if (push && fwe) m_fq = f;
      if (sclr) m_st = push ? f : 4'b0000;
      else if (push) m_st = m_st | f;
    end
    @(posedge clk);
    @(negedge clk);
    head = (sb.size() > 0) ? sb[0] : m_last;
    check("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
    check("out_data", 32'(out_data), 32'(head.data));
    check("out_flags", 32'(out_flags), 32'(head.flags));
    check("acc", 32'(acc), 32'(m_acc));
    check("flags_q", 32'(flags_q), 32'(m_fq));
    check("flags_sticky", 32'(flags_sticky), 32'(m_st));
  endtask

  task automatic push1(input logic [W-1:0] d, input logic [3:0] f, input logic ordy);
    cyc(1'b1, d, f, 1'b1, 1'b1, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    // Reset (two cycles)
    cyc(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'd77, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // First push: acc and head both 31 one cycle later
    cyc(1'b1, 16'd31, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("first_acc", 32'(acc), 32'd31);
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_data", 32'(out_data), 32'd31);
    idle(1'b1);
    idle(1'b1);  // empty: out_ready ignored, head holds 31
    check("empty_hold", 32'(out_data), 32'd31);

    // Overfill: five pushes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) begin
      push1(16'(i), 4'(i), 1'b0);
      if (i == 4) check("full_in_ready", 32'(in_ready), 32'd0);
    end
    // Pop while full with in_valid high: the push is refused
    cyc(1'b1, 16'd6, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_pop_head", 32'(out_data), 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("drained", 32'(out_valid), 32'd0);
    check("drained_hold", 32'(out_data), 32'd4);

    // Simultaneous push and pop at count 1
    push1(16'd9, 4'h9, 1'b0);
    cyc(1'b1, 16'd7, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pp_head", 32'(out_data), 32'd7);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    idle(1'b1);

    // acc_clr wins over acc_we; the FIFO still takes -13
    cyc(1'b1, -16'sd13, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_acc", 32'(acc), 32'd0);
    check("clr_fifo", 32'(out_data), 32'(16'hFFF3));
    idle(1'b1);

    // Sticky flags: clear first, then OR
    cyc(1'b1, 16'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 16'd2, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sticky_1", 32'(flags_sticky), 32'h1);
    cyc(1'b1, 16'd3, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sticky_2", 32'(flags_sticky), 32'h5);
    cyc(1'b1, 16'd4, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sticky_3", 32'(flags_sticky), 32'h2);
    check("flags_q_we", 32'(flags_q), 32'h4);
    idle(1'b1);
    // acc_we/flags_we without a push have no effect
    cyc(1'b0, 16'd55, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with pending contents and in_valid high
    for (int i = 0; i < 3; i++) push1(16'(100 + i), 4'(i), 1'b0);
    cyc(1'b1, 16'd99, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    check("rst2_acc", 32'(acc), 32'd0);
    push1(16'd200, 4'h3, 1'b0);
    idle(1'b1);
    check("rst2_pop", 32'(out_data), 32'd200);

    // Pseudo-random traffic
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(7) == 0), ($urandom_range(7) == 0), 1'($urandom), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/acc_flags_unit.md
ACC_FLAGS_UNIT -- requirements
Module: acc_flags_unit

Interface
REQ-001 Parameter W, default 16, sets the datapath width and matches the ALU operand/result width.
REQ-002 Parameter DEPTH, default 4, sets the result FIFO depth; it is a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 alu_result  input  W  signed ALU result (resultAccumulator of the ALU).
REQ-006 alu_flags  input  4  ALU flags, treated as an opaque 4-bit vector.
REQ-007 in_valid  input  1  alu_result/alu_flags are valid this cycle.
REQ-008 in_ready  output  1  block can accept a result this cycle.
REQ-009 acc_we  input  1  accepted result is written to the accumulator.
REQ-010 flags_we  input  1  accepted flags are written to the flags register.
REQ-011 acc_clr  input  1  clear the accumulator.
REQ-012 sticky_clr  input  1  clear the sticky flags.
REQ-013 acc  output  W  accumulator register, fed back to ALU operandA.
REQ-014 flags_q  output  4  last written flags.
REQ-015 flags_sticky  output  4  OR of all flags accepted since the last clear.
REQ-016 out_valid  output  1  FIFO head is valid.
REQ-017 out_ready  input  1  consumer accepts the head this cycle.
REQ-018 out_data  output  W  FIFO head result.
REQ-019 out_flags  output  4  FIFO head flags.

Function
REQ-020 A push occurs in a cycle with in_valid and in_ready both high; a pop occurs in a cycle with out_valid and out_ready both high.
REQ-021 in_ready shall equal (count < DEPTH); it depends only on registered state, with no combinational path from out_ready.
REQ-022 out_valid shall equal (count > 0); out_data and out_flags shall be driven from the head entry, with first-word latency of one cycle after the push.
REQ-023 On a push, the FIFO shall store {alu_result, alu_flags} at the write pointer, and the write pointer shall advance modulo DEPTH.
REQ-024 On a pop, the read pointer shall advance modulo DEPTH.
REQ-025 count shall be incremented on push-only, decremented on pop-only, and left unchanged on simultaneous push and pop.
REQ-026 When the FIFO is full, in_ready shall be low and no push shall occur, even if a pop occurs in the same cycle; there is no pass-through when full.
REQ-027 When the FIFO is empty, out_valid shall be low, out_ready shall be ignored, and out_data/out_flags shall hold their last values.
REQ-028 On a push with acc_we=1, acc shall take alu_result on the next edge.
REQ-029 acc_clr=1 shall set acc to 0 and shall take priority over a simultaneous acc_we write.
REQ-030 On a push with flags_we=1, flags_q shall take alu_flags.
REQ-031 flags_sticky shall be OR-ed with alu_flags on every push, regardless of flags_we.
REQ-032 sticky_clr=1 shall set flags_sticky to 0; if a push occurs in the same cycle, flags_sticky shall take that push's alu_flags, because the clear applies first and the OR second.
REQ-033 When no push occurs, acc_we and flags_we shall have no effect.
REQ-034 acc, flags_q and flags_sticky shall update in the same edge as the push, independent of FIFO occupancy at the time of the push.

Reset
REQ-035 While rst is high at a clock edge, the block shall set acc=0, flags_q=0, flags_sticky=0, count=0, both pointers=0 and out_data/out_flags=0; as a result out_valid=0 and in_ready=1 in the following cycle.
REQ-036 rst shall take priority over every other input in the same cycle, and FIFO contents pending at reset shall be discarded.

Verification
REQ-037 After reset, push alu_result=31 with flags=0000, acc_we=1 and out_ready=0. Required: next cycle acc=31, out_valid=1, out_data=31.
REQ-038 Push 5 entries (1..5) back-to-back with out_ready=0 and DEPTH=4. Required: in_ready=0 after the 4th push, the 5th is not accepted, and pops then return 1,2,3,4.
REQ-039 Set count=1 and apply push 7 with a simultaneous pop. Required: count stays 1 and the head becomes 7 next cycle.
REQ-040 Push alu_result=-13 with acc_we=1 and acc_clr=1 in the same cycle. Required: acc=0 and the FIFO holds -13.
REQ-041 Push flags 0001, then 0100, then push flags 0010 with sticky_clr=1. Required: flags_sticky goes 0001, 0101, then 0010.
REQ-042 Fill 3 entries, assert rst for one cycle with in_valid=1. Required: next cycle out_valid=0, in_ready=1, acc=0, and subsequent pops return only post-reset data.
